alu_op_sequencer: RTL and testbench

Registered, multi-cycle successor to the combinational ALU control decoder. It accepts a 5-bit controlType over a valid/ready handshake and drives the ALU, shifter, mult/div and HI/LO control lines from registers. It sequences multi-cycle MULT/DIV operations with configurable latency, keeps the branch condition type sticky, and flags divide-by-zero and illegal codes. It sits between the main control FSM and the ALU/MultDiv datapath.

---
 rtl/alu_ctrl_pkg.sv | 65 ++++++
 rtl/alu_ctrl_decode.sv | 37 +++
 rtl/alu_op_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: controlType codes,
// control-field encodings, FSM state constants and the decoded control word.
package alu_ctrl_pkg;

    localparam logic [4:0] CT_OP00 = 5'h00;
    localparam logic [4:0] CT_OP01 = 5'h01;
    localparam logic [4:0] CT_OP02 = 5'h02;
    localparam logic [4:0] CT_OP03 = 5'h03;
    localparam logic [4:0] CT_OP04 = 5'h04;
    localparam logic [4:0] CT_OP05 = 5'h05;
    localparam logic [4:0] CT_OP06 = 5'h06;
    localparam logic [4:0] CT_OP07 = 5'h07;
    localparam logic [4:0] CT_OP08 = 5'h08;
    localparam logic [4:0] CT_DIV  = 5'h09;
    localparam logic [4:0] CT_MULT = 5'h0A;
    localparam logic [4:0] CT_OP0B = 5'h0B;
    localparam logic [4:0] CT_OP0C = 5'h0C;
    localparam logic [4:0] CT_OP0D = 5'h0D;
    localparam logic [4:0] CT_BR0  = 5'h0E;
    localparam logic [4:0] CT_BR1  = 5'h0F;
    localparam logic [4:0] CT_BR2  = 5'h10;
    localparam logic [4:0] CT_BR3  = 5'h11;
    localparam logic [4:0] CT_OP12 = 5'h12;

    localparam logic [2:0] ALU_F0 = 3'b000;
    localparam logic [2:0] ALU_F1 = 3'b001;
    localparam logic [2:0] ALU_F2 = 3'b010;
    localparam logic [2:0] ALU_F3 = 3'b011;
    localparam logic [2:0] ALU_F4 = 3'b100;
    localparam logic [2:0] ALU_F5 = 3'b101;
    localparam logic [2:0] ALU_F6 = 3'b110;
    localparam logic [2:0] ALU_F7 = 3'b111;

    localparam logic [2:0] SRC_0 = 3'b000;
    localparam logic [2:0] SRC_1 = 3'b001;
    localparam logic [2:0] SRC_2 = 3'b010;
    localparam logic [2:0] SRC_3 = 3'b011;
    localparam logic [2:0] SRC_4 = 3'b100;
    localparam logic [2:0] SRC_5 = 3'b101;

    localparam logic [1:0] SMD_NONE = 2'b00;
    localparam logic [1:0] SMD_DIV  = 2'b01;
    localparam logic [1:0] SMD_MULT = 2'b10;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_EXEC    = 3'd1;
    localparam state_t ST_ISSUE   = 3'd2;
    localparam state_t ST_MD_WAIT = 3'd3;
    localparam state_t ST_FIN     = 3'd4;

    typedef struct packed {
        logic [2:0] aluop;
        logic       orop;
        logic       ovfop;
        logic       save;
        logic [2:0] srcout;
        logic       divop;
        logic       multop;
        logic       cond_we;
        logic [1:0] cond;
        logic       illegal;
    } ctrl_word_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational controlType -> control word decoder; anything outside
// the defined code set decodes to an all-zero word with the illegal flag set.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [4:0] code,
    output ctrl_word_t cw
);

    // Code table lookup
    always_comb begin
        cw = '0;
        case (code)
            CT_OP00: begin cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP01: begin cw.aluop = ALU_F1; cw.ovfop = 1'b1; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP02: begin cw.aluop = ALU_F2; cw.ovfop = 1'b1; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP03: begin cw.aluop = ALU_F3; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP04: begin cw.aluop = ALU_F4; cw.ovfop = 1'b1; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP05: begin cw.aluop = ALU_F5; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP06: begin cw.aluop = ALU_F6; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP07: begin cw.aluop = ALU_F7; cw.srcout = SRC_2; cw.save = 1'b1; end
            CT_OP08: begin cw.orop = 1'b1; cw.srcout = SRC_4; cw.save = 1'b1; end
            CT_DIV:  begin cw.divop = 1'b1; end
            CT_MULT: begin cw.multop = 1'b1; end
            CT_OP0B: begin cw.aluop = ALU_F1; cw.srcout = SRC_3; cw.save = 1'b1; end
            CT_OP0C: begin cw.srcout = SRC_1; cw.save = 1'b1; end
            CT_OP0D: begin cw.srcout = SRC_0; cw.save = 1'b1; end
            CT_BR0:  begin cw.aluop = ALU_F7; cw.cond_we = 1'b1; cw.cond = 2'b00; end
            CT_BR1:  begin cw.aluop = ALU_F7; cw.cond_we = 1'b1; cw.cond = 2'b01; end
            CT_BR2:  begin cw.aluop = ALU_F7; cw.cond_we = 1'b1; cw.cond = 2'b10; end
            CT_BR3:  begin cw.aluop = ALU_F7; cw.cond_we = 1'b1; cw.cond = 2'b11; end
            CT_OP12: begin cw.srcout = SRC_5; cw.save = 1'b1; end
            default: begin cw.illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: valid/ready request intake, single-cycle
// ALU ops, multi-cycle MULT/DIV sequencing, sticky branch condition.
module alu_op_sequencer #(
    parameter int CT_W        = 5,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CT_W-1:0] controlType,
    input  logic            div_zero,
    output logic [2:0]      ALUOp,
    output logic            divOp,
    output logic            multOp,
    output logic            orOp,
    output logic            overflowOp,
    output logic            ALUOutSave,
    output logic [2:0]      SrcOut,
    output logic [1:0]      StoreMD,
    output logic [1:0]      condType,
    output logic            busy,
    output logic            done,
    output logic            div_zero_exc,
    output logic            illegal
);
    import alu_ctrl_pkg::*;

    state_t          state_r;
    state_t          next_state_s;
    logic [CT_W-1:0] code_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic            exc_s;
    logic [4:0]      dec_code_s;
    ctrl_word_t      dec_s;

    logic [2:0] aluop_s;
    logic       divop_s;
    logic       multop_s;
    logic       orop_s;
    logic       ovfop_s;
    logic       save_s;
    logic [2:0] srcout_s;
    logic [1:0] storemd_s;
    logic [1:0] cond_s;
    logic       done_s;
    logic       exc_out_s;
    logic       illegal_s;
    logic       ready_s;

    // Outputs are registered from the next state, so in IDLE the decoder must
    // see the incoming code rather than the not-yet-latched one.
    assign dec_code_s = (state_r == ST_IDLE) ? controlType[4:0] : code_r[4:0];

    alu_ctrl_decode u_decode (
        .code (dec_code_s),
        .cw   (dec_s)
    );

    // Next-state and divide-by-zero exception detection
    always_comb begin
        next_state_s = state_r;
        exc_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (dec_s.divop || dec_s.multop) begin
                        next_state_s = ST_ISSUE;
                    end else begin
                        next_state_s = ST_EXEC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_IDLE;
            ST_ISSUE: begin
                if ((code_r[4:0] == CT_DIV) && div_zero) begin
                    next_state_s = ST_FIN;
                    exc_s        = 1'b1;
                end else begin
                    next_state_s = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_MD_WAIT;
                end
            end
            ST_FIN:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Latency counter: loaded with N-1 in ISSUE so MD_WAIT lasts exactly N cycles
    always_comb begin
        cnt_s = cnt_r;
        if (state_r == ST_ISSUE) begin
            if (code_r[4:0] == CT_DIV) begin
                cnt_s = CNT_W'(DIV_CYCLES - 1);
            end else begin
                cnt_s = CNT_W'(MULT_CYCLES - 1);
            end
        end else if ((state_r == ST_MD_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Moore output values for the state being entered
    always_comb begin
        aluop_s   = 3'b000;
        divop_s   = 1'b0;
        multop_s  = 1'b0;
        orop_s    = 1'b0;
        ovfop_s   = 1'b0;
        save_s    = 1'b0;
        srcout_s  = 3'b000;
        storemd_s = SMD_NONE;
        cond_s    = condType;
        done_s    = 1'b0;
        exc_out_s = 1'b0;
        illegal_s = 1'b0;
        ready_s   = (next_state_s == ST_IDLE);
        case (next_state_s)
            ST_EXEC: begin
                aluop_s   = dec_s.aluop;
                orop_s    = dec_s.orop;
                ovfop_s   = dec_s.ovfop;
                save_s    = dec_s.save;
                srcout_s  = dec_s.srcout;
                illegal_s = dec_s.illegal;
                done_s    = 1'b1;
                if (dec_s.cond_we) begin
                    cond_s = dec_s.cond;
                end else begin
                    cond_s = condType;
                end
            end
            ST_ISSUE: begin
                divop_s  = dec_s.divop;
                multop_s = dec_s.multop;
            end
            ST_FIN: begin
                done_s = 1'b1;
                if (exc_s) begin
                    exc_out_s = 1'b1;
                end else if (code_r[4:0] == CT_DIV) begin
                    storemd_s = SMD_DIV;
                end else begin
                    storemd_s = SMD_MULT;
                end
            end
            default: begin
                aluop_s = 3'b000;
            end
        endcase
    end

    // State, code latch, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            code_r       <= {CT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            ALUOp        <= 3'b000;
            divOp        <= 1'b0;
            multOp       <= 1'b0;
            orOp         <= 1'b0;
            overflowOp   <= 1'b0;
            ALUOutSave   <= 1'b0;
            SrcOut       <= 3'b000;
            StoreMD      <= 2'b00;
            condType     <= 2'b00;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_s;
            if ((state_r == ST_IDLE) && req_valid) begin
                code_r <= controlType;
            end
            req_ready    <= ready_s;
            busy         <= ~ready_s;
            ALUOp        <= aluop_s;
            divOp        <= divop_s;
            multOp       <= multop_s;
            orOp         <= orop_s;
            overflowOp   <= ovfop_s;
            ALUOutSave   <= save_s;
            SrcOut       <= srcout_s;
            StoreMD      <= storemd_s;
            condType     <= cond_s;
            done         <= done_s;
            div_zero_exc <= exc_out_s;
            illegal      <= illegal_s;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Random-stimulus bench for alu_op_sequencer: every cycle of every operation
// is compared against a table-driven model of the code set and latencies.
module tb_alu_op_sequencer;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 1;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] controlType;
    logic       div_zero;
    logic [2:0] ALUOp;
    logic       divOp, multOp, orOp, overflowOp, ALUOutSave;
    logic [2:0] SrcOut;
    logic [1:0] StoreMD;
    logic [1:0] condType;
    logic       busy, done, div_zero_exc, illegal;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] cond_m = 2'b00;

    alu_op_sequencer #(
        .CT_W(5), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .controlType(controlType), .div_zero(div_zero), .ALUOp(ALUOp),
        .divOp(divOp), .multOp(multOp), .orOp(orOp), .overflowOp(overflowOp),
        .ALUOutSave(ALUOutSave), .SrcOut(SrcOut), .StoreMD(StoreMD),
        .condType(condType), .busy(busy), .done(done),
        .div_zero_exc(div_zero_exc), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready,busy,done,ALUOp,divOp,multOp,orOp,ovf,save,SrcOut,StoreMD,cond,exc,illegal}
    function automatic logic [19:0] pack(input logic rdy, input logic bsy, input logic dn,
        input logic [2:0] alu, input logic dv, input logic ml, input logic orr,
        input logic ovf, input logic sv, input logic [2:0] src, input logic [1:0] smd,
        input logic [1:0] cnd, input logic exc, input logic ill);
        return {rdy, bsy, dn, alu, dv, ml, orr, ovf, sv, src, smd, cnd, exc, ill};
    endfunction

    function automatic logic [19:0] observed();
        return pack(req_ready, busy, done, ALUOp, divOp, multOp, orOp, overflowOp,
                    ALUOutSave, SrcOut, StoreMD, condType, div_zero_exc, illegal);
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] idle_vec(input logic [1:0] cnd);
        return pack(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, cnd, 1'b0, 1'b0);
    endfunction

    // Expected EXEC-cycle vector, built from the code table by ranges
    function automatic logic [19:0] exec_vec(input int code, input logic [1:0] cnd);
        logic [2:0] alu; logic orr; logic ovf; logic sv; logic [2:0] src; logic ill;
        alu = 3'd0; orr = 1'b0; ovf = 1'b0; sv = 1'b0; src = 3'd0; ill = 1'b0;
        if (code >= 8'h13) ill = 1'b1;
        else if (code >= 8'h0E && code <= 8'h11) alu = 3'd7;
        else begin
            sv = 1'b1;
            if (code >= 1 && code <= 7) alu = 3'(code);
            if (code == 8'h0B) alu = 3'd1;
            if (code == 1 || code == 2 || code == 4) ovf = 1'b1;
            if (code <= 6 || code == 8'h0B) src = 3'd3;
            else if (code == 7) src = 3'd2;
            else if (code == 8) begin src = 3'd4; orr = 1'b1; end
            else if (code == 8'h0C) src = 3'd1;
            else if (code == 8'h12) src = 3'd5;
            else src = 3'd0;
        end
        return pack(1'b0, 1'b1, 1'b1, alu, 1'b0, 1'b0, orr, ovf, sv, src, 2'd0, cnd, 1'b0, ill);
    endfunction

    // Issue one request right now and check every cycle until back in IDLE
    task automatic do_op(input int code, input logic dz, input logic hold);
        int lat;
        logic is_md, is_div, exc;
        logic [19:0] exp;
        is_div = (code == 9);
        is_md  = (code == 9) || (code == 10);
        exc    = is_div && dz;
        lat    = !is_md ? 1 : (exc ? 2 : (is_div ? DIV_N : MULT_N) + 2);
        req_valid = 1'b1; controlType = 5'(code); div_zero = dz;
        @(posedge clk); #1;
        req_valid = hold;
        if (code >= 8'h0E && code <= 8'h11) cond_m = 2'(code - 8'h0E);
        for (int c = 1; c <= lat; c++) begin
            controlType = 5'($urandom);
            if (!is_md) exp = exec_vec(code, cond_m);
            else if (c == 1)
                exp = pack(1'b0, 1'b1, 1'b0, 3'd0, is_div, !is_div, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, cond_m, 1'b0, 1'b0);
            else if (c < lat)
                exp = pack(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, cond_m, 1'b0, 1'b0);
            else
                exp = pack(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0,
                           exc ? 2'b00 : (is_div ? 2'b01 : 2'b10), cond_m, exc, 1'b0);
            check($sformatf("op%02h_c%0d", code, c), observed(), exp);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check($sformatf("op%02h_idle", code), observed(), idle_vec(cond_m));
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; controlType = 5'd0; div_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", observed(), idle_vec(2'b00));
        reset = 1'b1;
        @(posedge clk); #1;
        check("after_release", observed(), idle_vec(2'b00));

        // Directed cases
        do_op(8'h01, 1'b0, 1'b0);
        do_op(8'h0A, 1'b0, 1'b0);
        do_op(8'h09, 1'b1, 1'b0);
        do_op(8'h09, 1'b0, 1'b0);
        do_op(8'h10, 1'b0, 1'b0);
        do_op(8'h01, 1'b0, 1'b0);
        do_op(8'h0A, 1'b1, 1'b0);
        do_op(8'h15, 1'b0, 1'b1);
        do_op(8'h0A, 1'b0, 1'b1);
        for (int k = 0; k <= 8'h12; k++) do_op(k, 1'(k & 1), 1'b0);

        // Randomized traffic, sometimes with idle gaps
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                controlType = 5'($urandom);
                @(posedge clk); #1;
                check("gap_idle", observed(), idle_vec(cond_m));
            end
            do_op(int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a MULT clears everything, including condType
        do_op(8'h11, 1'b0, 1'b0);
        req_valid = 1'b1; controlType = 5'h0A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        cond_m = 2'b00;
        #2;
        check("midop_reset", observed(), idle_vec(2'b00));
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", observed(), idle_vec(2'b00));
        do_op(8'h03, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
